// File: rtl/button_debounce_pulse_if.sv
// Button-side signal bundle for the fire-button conditioner.
// The master drives the raw button; the slave returns the pulse, the debounced level and the press count.
interface button_debounce_pulse_if;
    logic       BIn;
    logic       B;
    logic       Level;
    logic [7:0] PressCnt;

    modport master (
        output BIn,
        input  B,
        input  Level,
        input  PressCnt
    );

    modport slave (
        input  BIn,
        output B,
        output Level,
        output PressCnt
    );
endinterface

// File: rtl/button_debounce_pulse.sv
// Fire-button conditioner: two-flop synchroniser, press/release debounce, and a post-release lockout.
// It emits one 1-cycle B pulse per qualified press and keeps a wrapping press count.
module button_debounce_pulse #(
    parameter int DB_CYCLES   = 4,
    parameter int LOCK_CYCLES = 8,
    parameter int CNT_W       = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    button_debounce_pulse_if.slave   bus
);

    typedef enum logic [2:0] {
        S_Idle,
        S_DbPress,
        S_Held,
        S_DbRel,
        S_Lock
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES);

    logic             sync1_q;
    logic             sync2_q;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc_d;
    logic             b_q;
    logic             level_q;
    logic [7:0]       press_cnt_q;
    logic             b_sync;

    assign b_sync    = sync2_q;
    assign cnt_inc_d = cnt_q + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            state_q     <= S_Idle;
            cnt_q       <= '0;
            b_q         <= 1'b0;
            level_q     <= 1'b0;
            press_cnt_q <= 8'd0;
        end else begin
            sync1_q <= bus.BIn;
            sync2_q <= sync1_q;
            b_q     <= 1'b0;
            case (state_q)
                S_Idle: begin
                    if (b_sync) begin
                        if (DB_CYCLES == 1) begin
                            b_q         <= 1'b1;
                            level_q     <= 1'b1;
                            press_cnt_q <= press_cnt_q + 8'd1;
                            state_q     <= S_Held;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= S_DbPress;
                        end
                    end
                end
                S_DbPress: begin
                    if (!b_sync) begin
                        state_q <= S_Idle;
                        cnt_q   <= '0;
                    end else if (cnt_inc_d == DB_LAST) begin
                        b_q         <= 1'b1;
                        level_q     <= 1'b1;
                        press_cnt_q <= press_cnt_q + 8'd1;
                        state_q     <= S_Held;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_Held: begin
                    if (!b_sync) begin
                        if (DB_CYCLES == 1) begin
                            level_q <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= (LOCK_CYCLES == 0) ? S_Idle : S_Lock;
                        end else begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= S_DbRel;
                        end
                    end
                end
                S_DbRel: begin
                    // A bounce back high keeps the level up and never re-fires B.
                    if (b_sync) begin
                        state_q <= S_Held;
                        cnt_q   <= '0;
                    end else if (cnt_inc_d == DB_LAST) begin
                        level_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= (LOCK_CYCLES == 0) ? S_Idle : S_Lock;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                S_Lock: begin
                    if (cnt_inc_d == LOCK_LAST) begin
                        state_q <= S_Idle;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_inc_d;
                    end
                end
                default: begin
                    state_q <= S_Idle;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.B        = b_q;
    assign bus.Level    = level_q;
    assign bus.PressCnt = press_cnt_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Directed bench for button_debounce_pulse: a vector table of per-cycle inputs and expected outputs,
// followed by a hand-written 256-press wrap sequence.
module tb_button_debounce_pulse;

    logic Clk;
    logic Rst;

    button_debounce_pulse_if bus ();

    button_debounce_pulse #(
        .DB_CYCLES   (4),
        .LOCK_CYCLES (8),
        .CNT_W       (4)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       bin;
        logic       rst;
        logic       b;
        logic       lvl;
        logic [7:0] cnt;
    } vec_t;

    vec_t vq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void add(logic bin, logic rst, logic b, logic lvl, int cnt, int n);
        vec_t v;
        v.bin = bin;
        v.rst = rst;
        v.b   = b;
        v.lvl = lvl;
        v.cnt = 8'(cnt);
        for (int i = 0; i < n; i++) vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive on the falling edge, then look at outputs 1 time unit after the rising edge.
    task automatic step(input logic bin, input logic rst);
        @(negedge Clk);
        bus.BIn = bin;
        Rst     = rst;
        @(posedge Clk);
        #1;
    endtask

    int pulses;

    initial begin
        bus.BIn = 1'b0;
        Rst     = 1'b1;

        // Reset state
        add(0, 1, 0, 0, 0, 2);
        // Clean press held 20 cycles: B on the 6th high cycle only
        add(1, 0, 0, 0, 0, 5);
        add(1, 0, 1, 1, 1, 1);
        add(1, 0, 0, 1, 1, 14);
        // Clean release, then lockout runs out
        add(0, 0, 0, 1, 1, 5);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 10);
        // Press bounce 1,1,0,1,1,1,0 then low
        add(1, 0, 0, 0, 1, 2);
        add(0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 1, 3);
        add(0, 0, 0, 0, 1, 8);
        // Press, then release bounce of 3 low cycles
        add(1, 0, 0, 0, 1, 5);
        add(1, 0, 1, 1, 2, 1);
        add(1, 0, 0, 1, 2, 3);
        add(0, 0, 0, 1, 2, 3);
        add(1, 0, 0, 1, 2, 6);
        // Real release
        add(0, 0, 0, 1, 2, 5);
        add(0, 0, 0, 0, 2, 1);
        // Five high cycles entirely inside the lockout
        add(1, 0, 0, 0, 2, 5);
        add(0, 0, 0, 0, 2, 10);
        // Press, release, then held high through the lockout
        add(1, 0, 0, 0, 2, 5);
        add(1, 0, 1, 1, 3, 1);
        add(1, 0, 0, 1, 3, 4);
        add(0, 0, 0, 1, 3, 5);
        add(0, 0, 0, 0, 3, 1);
        add(1, 0, 0, 0, 3, 11);
        add(1, 0, 1, 1, 4, 1);
        add(1, 0, 0, 1, 4, 3);
        add(0, 0, 0, 1, 4, 5);
        add(0, 0, 0, 0, 4, 1);
        add(0, 0, 0, 0, 4, 10);
        // Reset on the 4th high sample, button still held afterwards
        add(1, 0, 0, 0, 4, 5);
        add(1, 1, 0, 0, 0, 1);
        add(1, 0, 0, 0, 0, 5);
        add(1, 0, 1, 1, 1, 1);
        add(1, 0, 0, 1, 1, 2);
        add(0, 0, 0, 1, 1, 5);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 1, 10);

        foreach (vq[i]) begin
            step(vq[i].bin, vq[i].rst);
            chk($sformatf("vec%0d.B", i),        int'(bus.B),        int'(vq[i].b));
            chk($sformatf("vec%0d.Level", i),    int'(bus.Level),    int'(vq[i].lvl));
            chk($sformatf("vec%0d.PressCnt", i), int'(bus.PressCnt), int'(vq[i].cnt));
        end

        // Wrap: 256 clean presses from reset
        step(1'b0, 1'b1);
        chk("wrap.reset.PressCnt", int'(bus.PressCnt), 0);
        pulses = 0;
        for (int p = 1; p <= 256; p++) begin
            for (int c = 0; c < 8; c++) begin
                step(1'b1, 1'b0);
                if (bus.B) pulses++;
            end
            for (int c = 0; c < 16; c++) begin
                step(1'b0, 1'b0);
                if (bus.B) pulses++;
            end
            if (p == 1)   chk("wrap.after1.PressCnt",   int'(bus.PressCnt), 1);
            if (p == 255) chk("wrap.after255.PressCnt", int'(bus.PressCnt), 255);
            if (p == 256) chk("wrap.after256.PressCnt", int'(bus.PressCnt), 0);
        end
        chk("wrap.pulses", pulses, 256);
        chk("wrap.final.Level", int'(bus.Level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
